toy_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous SRAM between the RISC_TOY instruction-fetch port and data port.

---
 rtl/toy_mem_arbiter.sv | 108 ++++++++++
 tb/tb_toy_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/toy_mem_arbiter.sv
// Shares one single-port synchronous SRAM between the RISC_TOY fetch and data ports.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX denials.
module toy_mem_arbiter #(
    parameter int unsigned BW         = 32,
    parameter int unsigned AW         = 10,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          IREQ,
    input  logic [29:0]   IADDR,
    output logic          IGNT,
    output logic          IVALID,
    output logic [BW-1:0] INSTR,
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [29:0]   DADDR,
    input  logic [BW-1:0] DWDATA,
    output logic          DGNT,
    output logic          DVALID,
    output logic [BW-1:0] DRDATA,
    output logic          CSN,
    output logic          WEN,
    output logic [AW-1:0] A,
    output logic [BW-1:0] DI,
    input  logic [BW-1:0] DOUT
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IRD  = 2'd1,
        RSP_DRD  = 2'd2
    } rsp_t;

    rsp_t          rsp_owner;
    rsp_t          rsp_next;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_next;
    logic [BW-1:0] instr_q;
    logic [BW-1:0] drdata_q;
    logic          igrant;
    logic          dgrant;

    // Upper address bits are deliberately discarded: the SRAM address space wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{IADDR[29:AW], DADDR[29:AW]};

    // Response owner and starvation counter registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rsp_owner  <= RSP_NONE;
            starve_cnt <= '0;
        end else begin
            rsp_owner  <= rsp_next;
            starve_cnt <= starve_next;
        end
    end

    // Grant decision, next response owner and next starvation count
    always_comb begin
        igrant      = 1'b0;
        dgrant      = 1'b0;
        rsp_next    = RSP_NONE;
        starve_next = '0;
        if (RSTN) begin
            if (IREQ && (!DREQ || starve_cnt == CW'(STARVE_MAX))) begin
                igrant = 1'b1;
            end else if (DREQ) begin
                dgrant = 1'b1;
            end
        end
        if (igrant) begin
            rsp_next = RSP_IRD;
        end else if (dgrant && !DRW) begin
            rsp_next = RSP_DRD;
        end
        if (IREQ && !igrant) begin
            starve_next = (starve_cnt == CW'(STARVE_MAX)) ? starve_cnt : starve_cnt + CW'(1);
        end
    end

    // Last delivered words, held between responses
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            instr_q  <= '0;
            drdata_q <= '0;
        end else begin
            if (rsp_owner == RSP_IRD) instr_q  <= DOUT;
            if (rsp_owner == RSP_DRD) drdata_q <= DOUT;
        end
    end

    assign IGNT   = igrant;
    assign DGNT   = dgrant;
    assign IVALID = (rsp_owner == RSP_IRD);
    assign DVALID = (rsp_owner == RSP_DRD);
    assign INSTR  = IVALID ? DOUT : instr_q;
    assign DRDATA = DVALID ? DOUT : drdata_q;

    // SRAM pin drive
    assign CSN = ~(igrant | dgrant);
    assign WEN = ~(dgrant & DRW);
    assign A   = igrant ? IADDR[AW-1:0] : (dgrant ? DADDR[AW-1:0] : '0);
    assign DI  = (dgrant && DRW) ? DWDATA : '0;

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Directed self-checking bench for toy_mem_arbiter with a behavioural synchronous SRAM.
module tb_toy_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        IREQ;
    logic [29:0] IADDR;
    logic        IGNT;
    logic        IVALID;
    logic [31:0] INSTR;
    logic        DREQ;
    logic        DRW;
    logic [29:0] DADDR;
    logic [31:0] DWDATA;
    logic        DGNT;
    logic        DVALID;
    logic [31:0] DRDATA;
    logic        CSN;
    logic        WEN;
    logic [9:0]  A;
    logic [31:0] DI;
    logic [31:0] DOUT;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:1023];

    always #5 CLK = ~CLK;

    // Single-port synchronous SRAM: write at the edge, read data one cycle after
    always @(posedge CLK) begin
        if (!CSN) begin
            if (!WEN) mem[A] = DI;
            else      DOUT <= mem[A];
        end
    end

    toy_mem_arbiter #(.BW(32), .AW(10), .STARVE_MAX(3)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT), .IVALID(IVALID), .INSTR(INSTR),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
        .DGNT(DGNT), .DVALID(DVALID), .DRDATA(DRDATA),
        .CSN(CSN), .WEN(WEN), .A(A), .DI(DI), .DOUT(DOUT)
    );

    task automatic test_reset();
        RSTN = 1'b0; IREQ = 1'b1; DREQ = 1'b1; DRW = 1'b0;
        IADDR = 30'h5; DADDR = 30'h10; DWDATA = 32'h0;
        repeat (2) @(negedge CLK);
        #1;
        checks++; if (IGNT !== 1'b0)   begin failures++; $display("FAIL reset_ignt got=%b exp=0", IGNT); end
        checks++; if (DGNT !== 1'b0)   begin failures++; $display("FAIL reset_dgnt got=%b exp=0", DGNT); end
        checks++; if (CSN !== 1'b1)    begin failures++; $display("FAIL reset_csn got=%b exp=1", CSN); end
        checks++; if (WEN !== 1'b1)    begin failures++; $display("FAIL reset_wen got=%b exp=1", WEN); end
        checks++; if (A !== 10'h0)     begin failures++; $display("FAIL reset_a got=%h exp=0", A); end
        checks++; if (IVALID !== 1'b0) begin failures++; $display("FAIL reset_ivalid got=%b exp=0", IVALID); end
        checks++; if (DVALID !== 1'b0) begin failures++; $display("FAIL reset_dvalid got=%b exp=0", DVALID); end
        checks++; if (INSTR !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", INSTR); end
        checks++; if (DRDATA !== 32'h0) begin failures++; $display("FAIL reset_drdata got=%h exp=0", DRDATA); end
        @(negedge CLK);
        IREQ = 1'b0; DREQ = 1'b0; RSTN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_fetch();
        IREQ = 1'b1; IADDR = 30'h5;
        #1;
        checks++; if (IGNT !== 1'b1) begin failures++; $display("FAIL fetch_ignt got=%b exp=1", IGNT); end
        checks++; if (DGNT !== 1'b0) begin failures++; $display("FAIL fetch_dgnt got=%b exp=0", DGNT); end
        checks++; if (A !== 10'h5)   begin failures++; $display("FAIL fetch_a got=%h exp=5", A); end
        checks++; if (CSN !== 1'b0 || WEN !== 1'b1) begin failures++; $display("FAIL fetch_csn_wen got=%b%b exp=01", CSN, WEN); end
        @(negedge CLK);
        IREQ = 1'b0;
        #1;
        checks++; if (IVALID !== 1'b1) begin failures++; $display("FAIL fetch_ivalid got=%b exp=1", IVALID); end
        checks++; if (INSTR !== 32'h1A2B3C4D) begin failures++; $display("FAIL fetch_instr got=%h exp=1a2b3c4d", INSTR); end
        checks++; if (DVALID !== 1'b0) begin failures++; $display("FAIL fetch_dvalid got=%b exp=0", DVALID); end
        checks++; if (CSN !== 1'b1) begin failures++; $display("FAIL fetch_idle_csn got=%b exp=1", CSN); end
        @(negedge CLK);
        #1;
        checks++; if (IVALID !== 1'b0) begin failures++; $display("FAIL fetch_pulse got=%b exp=0", IVALID); end
        checks++; if (INSTR !== 32'h1A2B3C4D) begin failures++; $display("FAIL fetch_hold got=%h exp=1a2b3c4d", INSTR); end
    endtask

    task automatic test_write_read();
        @(negedge CLK);
        DREQ = 1'b1; DRW = 1'b1; DADDR = 30'h10; DWDATA = 32'hDEADBEEF;
        #1;
        checks++; if (DGNT !== 1'b1 || IGNT !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b%b exp=10", DGNT, IGNT); end
        checks++; if (WEN !== 1'b0) begin failures++; $display("FAIL wr_wen got=%b exp=0", WEN); end
        checks++; if (DI !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_di got=%h exp=deadbeef", DI); end
        checks++; if (A !== 10'h10) begin failures++; $display("FAIL wr_a got=%h exp=010", A); end
        @(negedge CLK);
        DRW = 1'b0; DWDATA = 32'h0;
        #1;
        checks++; if (DVALID !== 1'b0) begin failures++; $display("FAIL wr_no_dvalid got=%b exp=0", DVALID); end
        checks++; if (DGNT !== 1'b1 || WEN !== 1'b1) begin failures++; $display("FAIL rd_gnt_wen got=%b%b exp=11", DGNT, WEN); end
        checks++; if (DI !== 32'h0) begin failures++; $display("FAIL rd_di got=%h exp=0", DI); end
        @(negedge CLK);
        DREQ = 1'b0;
        #1;
        checks++; if (DVALID !== 1'b1) begin failures++; $display("FAIL rd_dvalid got=%b exp=1", DVALID); end
        checks++; if (DRDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_drdata got=%h exp=deadbeef", DRDATA); end
        checks++; if (IVALID !== 1'b0) begin failures++; $display("FAIL rd_ivalid got=%b exp=0", IVALID); end
    endtask

    task automatic test_starvation();
        logic prev_i;
        @(negedge CLK);
        IREQ = 1'b1; IADDR = 30'h20;
        DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h10;
        prev_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge CLK);
            #1;
            checks++;
            if (dut.starve_cnt !== 4'(i % 4)) begin
                failures++; $display("FAIL starve_cnt[%0d] got=%0d exp=%0d", i, dut.starve_cnt, i % 4);
            end
            checks++;
            if (IGNT !== ((i % 4) == 3) || DGNT !== ((i % 4) != 3)) begin
                failures++; $display("FAIL starve_gnt[%0d] got=i%b d%b exp=i%b", i, IGNT, DGNT, (i % 4) == 3);
            end
            if (i > 0) begin
                checks++;
                if (prev_i && (IVALID !== 1'b1 || DVALID !== 1'b0 || INSTR !== 32'h00C0FFEE)) begin
                    failures++; $display("FAIL b2b_irsp[%0d] got=iv%b dv%b %h exp=iv1 dv0 00c0ffee", i, IVALID, DVALID, INSTR);
                end else if (!prev_i && (DVALID !== 1'b1 || IVALID !== 1'b0 || DRDATA !== 32'hDEADBEEF)) begin
                    failures++; $display("FAIL b2b_drsp[%0d] got=dv%b iv%b %h exp=dv1 iv0 deadbeef", i, DVALID, IVALID, DRDATA);
                end
            end
            prev_i = ((i % 4) == 3);
        end
        @(negedge CLK);
        IREQ = 1'b0; DREQ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_wrap();
        IREQ = 1'b1; IADDR = 30'h7FF;
        #1;
        checks++; if (A !== 10'h3FF || IGNT !== 1'b1) begin failures++; $display("FAIL wrap_a got=%h g%b exp=3ff g1", A, IGNT); end
        @(negedge CLK);
        IREQ = 1'b0;
        #1;
        checks++; if (IVALID !== 1'b1 || INSTR !== 32'hCAFEF00D) begin failures++; $display("FAIL wrap_instr got=v%b %h exp=v1 cafef00d", IVALID, INSTR); end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_read();
        IREQ = 1'b1; IADDR = 30'h5;
        #1;
        checks++; if (IGNT !== 1'b1) begin failures++; $display("FAIL mid_ignt got=%b exp=1", IGNT); end
        @(posedge CLK);
        #2;
        RSTN = 1'b0; IREQ = 1'b0;
        #1;
        checks++; if (IVALID !== 1'b0) begin failures++; $display("FAIL mid_ivalid_rst got=%b exp=0", IVALID); end
        checks++; if (INSTR !== 32'h0) begin failures++; $display("FAIL mid_instr_rst got=%h exp=0", INSTR); end
        @(negedge CLK);
        RSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (IVALID !== 1'b0 || DVALID !== 1'b0 || INSTR !== 32'h0) begin
                failures++; $display("FAIL mid_after[%0d] got=iv%b dv%b %h exp=iv0 dv0 0", i, IVALID, DVALID, INSTR);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h005] = 32'h1A2B3C4D;
        mem[10'h020] = 32'h00C0FFEE;
        mem[10'h3FF] = 32'hCAFEF00D;
        test_reset();
        test_fetch();
        test_write_read();
        test_starvation();
        test_wrap();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
